// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte-in / serial-out handshake bundle between the uart_tx core and its driver.
interface uart_tx_if #(
    parameter int N_DATA_BITS = 8
);
    logic                   tick;
    logic                   tx_start;
    logic [N_DATA_BITS-1:0] data_in;
    logic                   tx;
    logic                   busy;
    logic                   tx_done;

    modport master (
        output tick, tx_start, data_in,
        input  tx, busy, tx_done
    );

    modport slave (
        input  tick, tx_start, data_in,
        output tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - tick-paced UART serialiser (start, LSB-first data, optional even parity, stop).
// Define UART_TX_PARITY_EN to compile in the even-parity bit between data and stop.
module uart_tx #(
    parameter int N_DATA_BITS = 8,
    parameter int N_TICKS     = 16,
    parameter int SB_TICKS    = 16
) (
    input  logic      clock,
    input  logic      reset,
    uart_tx_if.slave  bus
);
    localparam int S_MAX = (N_TICKS > SB_TICKS) ? N_TICKS : SB_TICKS;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

    localparam logic [S_W-1:0] BIT_LAST  = S_W'(N_TICKS - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] DATA_LAST = N_W'(N_DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [S_W-1:0]         s_q, s_d;
    logic [N_W-1:0]         n_q, n_d;
    logic [N_DATA_BITS-1:0] b_q, b_d;
    logic                   tx_q, tx_d;
    logic                   done;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is captured at acceptance.
    logic                   par_q, par_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    b_d     = bus.data_in;
                    s_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (bus.tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bus.tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is derived from the next state so tx moves in lockstep with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.tx_done = done & ~reset;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx, cycle-accurate line and handshake checks.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.N_DATA_BITS(8)) bus ();

    uart_tx #(.N_DATA_BITS(8), .N_TICKS(16), .SB_TICKS(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int TOTAL_TICKS = (1 + 8 + P) * 16 + 16;

    int n_checks = 0;
    int n_err    = 0;
    int ph       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.tick     = 1'b1;
            #1;
            check_eq($sformatf("%s tx c%0d", tag, i), bus.tx, 1);
            check_eq($sformatf("%s busy c%0d", tag, i), bus.busy, 0);
            check_eq($sformatf("%s done c%0d", tag, i), bus.tx_done, 0);
        end
    endtask

    // Starts in IDLE; the line level expected each cycle follows the count of ticks consumed.
    task automatic run_frame(input logic [7:0] d, input int div, input bit keep_start,
                             input int inject_cyc, input string tag);
        logic bits [0:10];
        int   tc, cyc, limit;
        bit   prev_tick, exp_done;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        bits[9]  = (P == 1) ? ^d : 1'b1;
        bits[10] = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.data_in  = d;
        bus.tick     = (ph == 0);
        ph = (ph + 1) % div;
        #1;
        check_eq({tag, " idle tx"}, bus.tx, 1);
        check_eq({tag, " idle busy"}, bus.busy, 0);
        check_eq({tag, " idle done"}, bus.tx_done, 0);
        @(posedge clk);
        #1;
        check_eq({tag, " accept tx"}, bus.tx, 0);
        check_eq({tag, " accept busy"}, bus.busy, 1);
        tc = 0; cyc = 0; prev_tick = 1'b0; exp_done = 1'b0;
        limit = TOTAL_TICKS * div + 50;
        while (!exp_done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (prev_tick) tc++;
            if (cyc == inject_cyc) begin
                bus.tx_start = 1'b1;
                bus.data_in  = 8'hFF;
            end else begin
                bus.tx_start = keep_start;
            end
            bus.tick = (ph == 0);
            ph = (ph + 1) % div;
            prev_tick = bus.tick;
            exp_done = bus.tick && (tc == TOTAL_TICKS - 1);
            #1;
            check_eq($sformatf("%s tx c%0d", tag, cyc), bus.tx, bits[tc / 16]);
            check_eq($sformatf("%s busy c%0d", tag, cyc), bus.busy, 1);
            check_eq($sformatf("%s done c%0d", tag, cyc), bus.tx_done, exp_done);
        end
        check_eq({tag, " frame ended"}, exp_done, 1);
        if (div == 1) check_eq({tag, " frame_len"}, cyc, TOTAL_TICKS);
    endtask

    initial begin
        bus.tick     = 1'b0;
        bus.tx_start = 1'b0;
        bus.data_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset tx", bus.tx, 1);
        check_eq("reset busy", bus.busy, 0);
        check_eq("reset done", bus.tx_done, 0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(8'hA5, 1, 1'b0, -1, "a5");
        idle_cycles(3, "post_a5");
        run_frame(8'h00, 4, 1'b0, -1, "pace00");
        idle_cycles(3, "post_pace");
        run_frame(8'h0F, 1, 1'b0, 40, "ign0f");
        idle_cycles(40, "no_second");
        run_frame(8'h3C, 1, 1'b1, -1, "b2b3c");
        run_frame(8'hC3, 1, 1'b0, -1, "b2bc3");
        idle_cycles(5, "post_b2b");
        run_frame(8'h07, 1, 1'b0, -1, "p07");
        run_frame(8'h03, 1, 1'b0, -1, "p03");
        idle_cycles(2, "post_par");

        @(negedge clk);
        bus.tx_start = 1'b1;
        bus.data_in  = 8'h5A;
        bus.tick     = 1'b1;
        repeat (50) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
        end
        check_eq("midframe busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst tx", bus.tx, 1);
        check_eq("midrst busy", bus.busy, 0);
        check_eq("midrst done", bus.tx_done, 0);
        @(posedge clk);
        #1;
        check_eq("midrst2 tx", bus.tx, 1);
        check_eq("midrst2 busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(8'hA5, 1, 1'b0, -1, "clean_a5");
        idle_cycles(3, "end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter driven by the oversampling `tick` from `baudrategen` (with `N_COUNT=163`, one tick per 1/16 bit at 19200 baud).
- Accepts a parallel byte from the interface/ALU side on a start strobe.
- Serialises it LSB-first as start bit, data bits, an optional parity bit and a stop period.
- Pairs with the UART receiver on the other end of the line; both count the same tick stream.

## Interface
Parameters:
- `N_DATA_BITS`, 8, data bits per frame.
- `N_TICKS`, 16, ticks per start/data/parity bit (oversampling factor).
- `SB_TICKS`, 16, ticks in the stop period (16 = 1 stop bit, 32 = 2).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle oversampling strobe from `baudrategen`.
- `tx_start`  in  1  request to send `data_in`; sampled only in IDLE.
- `data_in`  in  N_DATA_BITS  byte to transmit; latched when `tx_start` is accepted.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from acceptance until return to IDLE.
- `tx_done`  out  1  one-cycle pulse at end of stop period.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Internal registers:
  - tick counter `s`, width clog2(max(N_TICKS,SB_TICKS)).
  - bit index `n`, width clog2(N_DATA_BITS).
  - shift register `b`, N_DATA_BITS wide.
  - registered `tx`.
- IDLE:
  - `tx`=1.
  - On `tx_start`=1: latch `data_in` into `b`, clear `s`, go to START.
- START:
  - `tx`=0.
  - On `tick` with `s`=N_TICKS-1: clear `s` and `n`, go to DATA.
  - Otherwise, on `tick`, `s`++.
- DATA:
  - `tx`=`b[0]`.
  - On `tick` with `s`=N_TICKS-1: clear `s` and shift `b` right.
    - If `n`=N_DATA_BITS-1, go to PARITY or STOP.
    - Otherwise `n`++.
- PARITY: `tx`=XOR of the original byte (even parity). Leaves after N_TICKS ticks, to STOP.
- STOP:
  - `tx`=1.
  - On `tick` with `s`=SB_TICKS-1: assert `tx_done` for that cycle and go to IDLE.
- `tx_start` outside IDLE is ignored; no queuing.
- Cycles without `tick` hold all state.
- Reset values (any state, including mid-frame): state=IDLE, `tx`=1, `busy`=0, `tx_done`=0, `s`=0, `n`=0, `b`=0. A frame cut by reset is abandoned; the line returns high on the next edge.

## Timing
- Acceptance: `tx_start` high at edge k puts state=START and `tx`=0 after edge k.
- `busy`=1 from edge k.
- `tx` is registered and changes only at clock edges following a qualifying `tick`.
- Each start/data/parity bit lasts exactly N_TICKS ticks; the stop period lasts exactly SB_TICKS ticks.
- `tx_done` and the STOP→IDLE transition occur at the same edge; `busy` falls at that edge.
- Back-to-back frames:
  - A `tx_start` held high through the `tx_done` cycle is accepted on the following cycle, one clock of IDLE.
  - Minimum gap between frames is one clock of idle-high `tx`.
- `tick` asserted on every clock gives a frame of (1+N_DATA_BITS)·N_TICKS+SB_TICKS clocks, plus N_TICKS with parity. Defaults: 160 clocks, or 176 with parity.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - Frame = start + data + even parity + stop.
- Not defined:
  - No PARITY state; DATA goes directly to STOP.
  - Frame = start + data + stop (8N1 at defaults).
- Port list is identical in both builds.

## Test plan
- Reset: hold `reset`=1 for 2 cycles mid-frame → `tx`=1, `busy`=0, `tx_done`=0 on the next edge. The following `tx_start` produces a full clean frame.
- Basic frame, no macro, `tick` every clock, `data_in`=0xA5:
  - `tx` = 0 for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then 1 for 16 clocks.
  - `tx_done` pulses exactly 160 clocks after acceptance.
- Tick pacing: `tick` once every 4 clocks, `data_in`=0x00 → each bit spans 64 clocks; state frozen between ticks.
- Ignored start: pulse `tx_start` with `data_in`=0xFF during DATA of a 0x0F frame → the 0x0F frame completes unchanged and no second frame follows.
- Back-to-back: hold `tx_start`=1 with 0x3C, then 0xC3 → one idle clock between the frames, two `tx_done` pulses, both bytes correct on `tx`.
- Parity build, `UART_TX_PARITY_EN` defined: 0x07 gives parity bit 1 and 0x03 gives 0; the 16-clock parity slot sits before stop, and `tx_done` comes 176 clocks after acceptance.
